// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Two-requester arbiter and sequencer for the single-port data memory.
//   The pipeline MEM stage (cpu_*) and an external loader/debug port (ext_*)
//   share the memory. Each granted access runs through a fixed-latency memory
//   cycle of MEM_LAT enable cycles. The pipeline is stalled while a CPU access
//   is outstanding. Ties alternate between the two sides.
//
// Parameters
//   ADDR_W   word-address width (byte address bits [ADDR_W+1:2])
//   DATA_W   data width
//   MEM_LAT  cycles mem_en is held per access, 1..7
//
// Ports
//   clock                 system clock, rising edge
//   reset                 asynchronous, active-low (0 = reset)
//   cpu_req/we/addr/wdata MEM-stage request, held until cpu_stall drops
//   cpu_rdata             load data, valid in the cycle cpu_stall falls
//   cpu_stall             freeze pc/if_id/id_exe/exe_mem while high
//   ext_req/we/addr/wdata external request, held until ext_ack
//   ext_rdata             read data, valid while ext_ack = 1
//   ext_ack               one-cycle completion pulse
//   mem_en/we/addr/wdata  memory command (mem_we qualified by mem_en)
//   mem_rdata             memory read data, valid on the last ACCESS cycle
//   busy                  high while the sequencer is not idle
//
// Optional feature: define DM_ARB_STATS_EN to add the saturating grant/wait
// counters stat_cpu, stat_ext and stat_wait.
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_ext,
  output logic [15:0]       stat_wait
`endif
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
      $error("dm_arbiter: MEM_LAT=%0d is outside the legal range 1..7", MEM_LAT);
    end
  endgenerate

  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_CPU = 1'b0,
    SIDE_EXT = 1'b1
  } side_t;

  state_t     state;
  side_t      grant;
  side_t      last_grant;
  logic [2:0] cnt;

  side_t      winner;
  logic       any_req;

  assign any_req = cpu_req | ext_req;

  // A lone requester wins; on a tie the side that did not win last time wins.
  always_comb begin
    winner = SIDE_CPU;
    if (ext_req && (!cpu_req || last_grant == SIDE_CPU)) begin
      winner = SIDE_EXT;
    end
  end

  // Gated by reset so every output reads 0 while reset is held, even with
  // cpu_req high.
  assign cpu_stall = reset & cpu_req & ~((state == S_DONE) && (grant == SIDE_CPU));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= SIDE_CPU;
      last_grant <= SIDE_EXT;
      cnt        <= 3'd0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
      ext_ack    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            state      <= S_ACCESS;
            busy       <= 1'b1;
            cnt        <= 3'd0;
            grant      <= winner;
            last_grant <= winner;
            mem_en     <= 1'b1;
            if (winner == SIDE_EXT) begin
              mem_we    <= ext_we;
              mem_addr  <= ext_addr;
              mem_wdata <= ext_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end

        S_ACCESS: begin
          if (cnt == CNT_LAST) begin
            state  <= S_DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // Writes leave the requester's read register untouched.
            if (!mem_we) begin
              if (grant == SIDE_EXT) begin
                ext_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            if (grant == SIDE_EXT) begin
              ext_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        S_DONE: begin
          // Requests are not sampled here; arbitration resumes in IDLE.
          state   <= S_IDLE;
          busy    <= 1'b0;
          ext_ack <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          ext_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A side waits when it requests while the other side owns the sequencer.
  // The owning side is the one in DONE, so DONE never counts for itself, and
  // IDLE cycles carry no owner.
  logic wait_now;
  assign wait_now = (state != S_IDLE) &&
                    ((cpu_req && grant != SIDE_CPU) || (ext_req && grant != SIDE_EXT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cpu  <= 16'd0;
      stat_ext  <= 16'd0;
      stat_wait <= 16'd0;
    end else begin
      if (state == S_IDLE && any_req) begin
        if (winner == SIDE_EXT) begin
          stat_ext <= sat_inc(stat_ext);
        end else begin
          stat_cpu <= sat_inc(stat_cpu);
        end
      end
      if (wait_now) begin
        stat_wait <= sat_inc(stat_wait);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//   Directed bench for dm_arbiter (MEM_LAT = 2). Each issued transaction pushes
//   its expected completion (side + read data) into a scoreboard queue; a
//   monitor pops and compares whenever the DUT completes an access. Timing,
//   stall length, reset behaviour and tie ordering are checked inline.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ext_req = 1'b0, ext_we = 1'b0;
  logic [ADDR_W-1:0] ext_addr = '0;
  logic [DATA_W-1:0] ext_wdata = '0;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
`ifdef DM_ARB_STATS_EN
  logic [15:0]       stat_cpu, stat_ext, stat_wait;
`endif

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef DM_ARB_STATS_EN
    , .stat_cpu(stat_cpu), .stat_ext(stat_ext), .stat_wait(stat_wait)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: unwritten words read back their own address.
  bit [31:0] mem_arr [1024];
  bit        mem_wr  [1024];
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      mem_wr[mem_addr]  <= 1'b1;
    end
  end
  assign mem_rdata = mem_wr[mem_addr] ? mem_arr[mem_addr] : {22'd0, mem_addr};

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ext;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input bit e, input logic [31:0] d);
    exp_t x;
    x.is_ext = e;
    x.rdata  = d;
    sb_q.push_back(x);
  endtask

  // Scoreboard monitor: a completion is ext_ack or the cycle cpu_stall falls.
  always @(negedge clock) begin
    if (reset && (ext_ack || (cpu_req && !cpu_stall))) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_completion", {31'd0, ext_ack}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_side_is_ext", {31'd0, ext_ack}, {31'd0, e.is_ext});
        check("sb_rdata", ext_ack ? ext_rdata : cpu_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Caller is at posedge+1 of an IDLE cycle (cycle 0). idx = completion cycle.
  task automatic cpu_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                         output int idx, output int en_c, output int st_c);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    idx = -1; en_c = 0; st_c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_en) en_c++;
      if (cpu_stall) st_c++;
      else begin
        idx = i;
        break;
      end
    end
    @(posedge clock); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ext_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                         output int idx);
    ext_we = we; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ext_ack) begin
        idx = i;
        break;
      end
    end
    @(posedge clock); #1;
    ext_req = 1'b0;
    @(negedge clock);
    check("ext_ack_single_pulse", {31'd0, ext_ack}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int idx, en_c, st_c, ncomp, nbusy, nst, ack_i, cpu_i;
    int cidx [3];
    bit a_seen, c_seen;

    // Reset state, with cpu_req high to show cpu_stall is held low too.
    cpu_req = 1'b1;
    #12;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ext_rdata", ext_rdata, 32'd0);
    check("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // CPU load alone, then a CPU store that must not disturb cpu_rdata.
    push_exp(1'b0, 32'h0000_0004);
    cpu_txn(1'b0, 10'h004, 32'd0, idx, en_c, st_c);
    check("s1_load_done_cycle", idx, 32'd3);
    check("s1_mem_en_cycles", en_c, 32'd2);
    check("s1_stall_cycles", st_c, 32'd3);
    check("s1_busy_after", {31'd0, busy}, 32'd0);
    push_exp(1'b0, 32'h0000_0004);
    cpu_txn(1'b1, 10'h008, 32'hCAFE_0001, idx, en_c, st_c);
    check("s1_store_done_cycle", idx, 32'd3);
    check("s1_store_mem", mem_arr[8], 32'hCAFE_0001);

    // EXT write then read back.
    push_exp(1'b1, 32'h0000_0000);
    ext_txn(1'b1, 10'h010, 32'hDEAD_BEEF, idx);
    check("s2_write_ack_cycle", idx, 32'd3);
    push_exp(1'b1, 32'hDEAD_BEEF);
    ext_txn(1'b0, 10'h010, 32'd0, idx);
    check("s2_read_ack_cycle", idx, 32'd3);

    // Tie right after reset, both requests held: CPU, EXT, CPU.
    do_reset();
    push_exp(1'b0, 32'h0000_0020);
    push_exp(1'b1, 32'h0000_0021);
    push_exp(1'b0, 32'h0000_0020);
    cpu_we = 1'b0; cpu_addr = 10'h020; cpu_req = 1'b1;
    ext_we = 1'b0; ext_addr = 10'h021; ext_req = 1'b1;
    ncomp = 0; nbusy = 0;
    for (int k = 0; k < 3; k++) cidx[k] = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) nbusy++;
      if (ext_ack || (cpu_req && !cpu_stall)) begin
        cidx[ncomp] = i;
        ncomp++;
      end
      if (ncomp == 3) begin
`ifdef DM_ARB_STATS_EN
        check("s6_stat_cpu", {16'd0, stat_cpu}, 32'd2);
        check("s6_stat_ext", {16'd0, stat_ext}, 32'd1);
        check("s6_stat_wait", {16'd0, stat_wait}, 32'd8);
`endif
        break;
      end
    end
    @(posedge clock); #1;
    cpu_req = 1'b0; ext_req = 1'b0;
    check("s3_completions", ncomp, 32'd3);
    check("s3_done1_cycle", cidx[0], 32'd3);
    check("s3_done2_cycle", cidx[1], 32'd7);
    check("s3_done3_cycle", cidx[2], 32'd11);
    check("s3_busy_cycles", nbusy, 32'd9);
    @(negedge clock);
    check("s3_busy_after", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;

    // EXT in progress when cpu_req rises in EXT's first ACCESS cycle.
    push_exp(1'b1, 32'h0000_0030);
    push_exp(1'b0, 32'h0000_0031);
    ext_we = 1'b0; ext_addr = 10'h030; ext_req = 1'b1;
    nst = 0; ack_i = -1; cpu_i = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cpu_stall) nst++;
      a_seen = ext_ack;
      c_seen = cpu_req && !cpu_stall;
      if (a_seen) ack_i = i;
      if (c_seen) cpu_i = i;
      @(posedge clock); #1;
      if (i == 0) begin
        cpu_we = 1'b0; cpu_addr = 10'h031; cpu_req = 1'b1;
        #1;
        check("s4_stall_immediate", {31'd0, cpu_stall}, 32'd1);
      end
      if (a_seen) ext_req = 1'b0;
      if (c_seen) begin
        cpu_req = 1'b0;
        break;
      end
    end
    check("s4_ext_ack_cycle", ack_i, 32'd3);
    check("s4_cpu_done_cycle", cpu_i, 32'd7);
    check("s4_stall_cycles", nst, 32'd6);

    // Reset during the first ACCESS cycle of an EXT write.
    ext_we = 1'b1; ext_addr = 10'h040; ext_wdata = 32'h1234_5678; ext_req = 1'b1;
    @(posedge clock); #1;
    check("s5_pre_mem_en", {31'd0, mem_en}, 32'd1);
    check("s5_pre_mem_we", {31'd0, mem_we}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s5_mem_en", {31'd0, mem_en}, 32'd0);
    check("s5_mem_we", {31'd0, mem_we}, 32'd0);
    check("s5_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("s5_mem_wdata", mem_wdata, 32'd0);
    check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_ext_rdata", ext_rdata, 32'd0);
    check("s5_cpu_rdata", cpu_rdata, 32'd0);
    ext_req = 1'b0;
    repeat (2) @(posedge clock);
    check("s5_write_not_done", {31'd0, mem_wr[64]}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    push_exp(1'b0, 32'h0000_0050);
    push_exp(1'b1, 32'h0000_0051);
    cpu_we = 1'b0; cpu_addr = 10'h050; cpu_req = 1'b1;
    ext_we = 1'b0; ext_addr = 10'h051; ext_req = 1'b1;
    ack_i = -1; cpu_i = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      a_seen = ext_ack;
      c_seen = cpu_req && !cpu_stall;
      if (a_seen) ack_i = i;
      if (c_seen) cpu_i = i;
      @(posedge clock); #1;
      if (a_seen) ext_req = 1'b0;
      if (c_seen) cpu_req = 1'b0;
      if (!cpu_req && !ext_req) break;
    end
    check("s5_cpu_first_cycle", cpu_i, 32'd3);
    check("s5_ext_second_cycle", ack_i, 32'd7);

    repeat (2) @(posedge clock);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
